// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared definitions for the matmul tile sequencer.
//   - Tile geometry (edge, tile-index width, maximum tiles per dimension)
//   - Sequencer state encoding and error codes
//   - mask_from_count: validity mask with the low 'count' bits set, saturating at
//     a full tile. The host driver model builds its masks with the same rule.
package matmul_tile_sequencer_pkg;

    localparam int TILE_EDGE  = 8;
    localparam int TILE_SHIFT = $clog2(TILE_EDGE);
    localparam int MAX_TILES  = 16;
    localparam int TILE_IDX_W = $clog2(MAX_TILES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SETUP,
        ST_START,
        ST_WAIT_DONE,
        ST_CLEAR,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_BAD_CFG = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ABORTED = 2'b11
    } seq_err_t;

    function automatic logic [TILE_EDGE-1:0] mask_from_count(input logic [31:0] count);
        logic [TILE_EDGE-1:0] mask;
        mask = '0;
        for (int i = 0; i < TILE_EDGE; i++) begin
            mask[i] = (32'(i) < count);
        end
        return mask;
    endfunction

endpackage

// File: rtl/matmul_tile_sequencer_addr_gen.sv
// matmul_tile_addr_gen: tile row/column counters and running address accumulators.
// Addresses are built incrementally (no multipliers); all sums wrap mod 2^AWIDTH.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   clear              load base addresses, zero tile counters
//   inc_col            next tile in the same row
//   inc_row            first tile of the next row (takes priority over inc_col)
//   base_a/b/c         job base addresses
//   step_a/b/c_col/c_row  per-tile address deltas
//   tile_row/tile_col  current tile coordinates
//   addr_a/b/c         addresses of the current tile
module matmul_tile_addr_gen
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH     = 11,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  inc_col,
    input  logic                  inc_row,
    input  logic [AWIDTH-1:0]     base_a,
    input  logic [AWIDTH-1:0]     base_b,
    input  logic [AWIDTH-1:0]     base_c,
    input  logic [STEP_WIDTH-1:0] step_a,
    input  logic [STEP_WIDTH-1:0] step_b,
    input  logic [STEP_WIDTH-1:0] step_c_col,
    input  logic [STEP_WIDTH-1:0] step_c_row,
    output logic [TILE_IDX_W-1:0] tile_row,
    output logic [TILE_IDX_W-1:0] tile_col,
    output logic [AWIDTH-1:0]     addr_a,
    output logic [AWIDTH-1:0]     addr_b,
    output logic [AWIDTH-1:0]     addr_c
);

    logic [TILE_IDX_W-1:0] tr_q, tr_d, tc_q, tc_d;
    // acc_c_row carries base_c plus the row offset; acc_c_col only the column offset,
    // so a row change can reset the column part without touching the row part.
    logic [AWIDTH-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [AWIDTH-1:0] acc_c_row_q, acc_c_row_d, acc_c_col_q, acc_c_col_d;

    always_comb begin
        tr_d        = tr_q;
        tc_d        = tc_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        acc_c_row_d = acc_c_row_q;
        acc_c_col_d = acc_c_col_q;
        if (clear) begin
            tr_d        = '0;
            tc_d        = '0;
            acc_a_d     = base_a;
            acc_b_d     = base_b;
            acc_c_row_d = base_c;
            acc_c_col_d = '0;
        end else if (inc_row) begin
            tr_d        = tr_q + 1'b1;
            tc_d        = '0;
            acc_a_d     = acc_a_q + AWIDTH'(step_a);
            acc_b_d     = base_b;
            acc_c_row_d = acc_c_row_q + AWIDTH'(step_c_row);
            acc_c_col_d = '0;
        end else if (inc_col) begin
            tc_d        = tc_q + 1'b1;
            acc_b_d     = acc_b_q + AWIDTH'(step_b);
            acc_c_col_d = acc_c_col_q + AWIDTH'(step_c_col);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tr_q        <= '0;
            tc_q        <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            acc_c_row_q <= '0;
            acc_c_col_q <= '0;
        end else begin
            tr_q        <= tr_d;
            tc_q        <= tc_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            acc_c_row_q <= acc_c_row_d;
            acc_c_col_q <= acc_c_col_d;
        end
    end

    assign tile_row = tr_q;
    assign tile_col = tc_q;
    assign addr_a   = acc_a_q;
    assign addr_b   = acc_b_q;
    assign addr_c   = acc_c_row_q + acc_c_col_q;

endmodule

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: walks the 8x8 output tiles of an M x N product (shared K <= 8)
// row-major, programming one matmul wrapper per tile: addresses + masks, start, wait for
// done, clear. Sits between the host register file and the matmul wrapper.
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   cfg_start / cfg_abort          job start pulse (IDLE only) / stop after current tile
//   cfg_m, cfg_n, cfg_k            job dimensions
//   cfg_base_*, cfg_step_*         base addresses and per-tile address deltas
//   busy, done, err, tiles_done    host status
//   mm_done                        wrapper done (level)
//   mm_start_reg, mm_clear_done    wrapper start / clear-done controls
//   mm_addr_*, mm_mask_*           per-tile addresses and validity masks
module matmul_tile_sequencer
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH         = 11,
    parameter int MAT_MUL_SIZE   = TILE_EDGE,
    parameter int DIM_WIDTH      = 8,
    parameter int STEP_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [DIM_WIDTH-1:0]    cfg_m,
    input  logic [DIM_WIDTH-1:0]    cfg_n,
    input  logic [DIM_WIDTH-1:0]    cfg_k,
    input  logic [AWIDTH-1:0]       cfg_base_a,
    input  logic [AWIDTH-1:0]       cfg_base_b,
    input  logic [AWIDTH-1:0]       cfg_base_c,
    input  logic [STEP_WIDTH-1:0]   cfg_step_a,
    input  logic [STEP_WIDTH-1:0]   cfg_step_b,
    input  logic [STEP_WIDTH-1:0]   cfg_step_c_col,
    input  logic [STEP_WIDTH-1:0]   cfg_step_c_row,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic [7:0]              tiles_done,
    input  logic                    mm_done,
    output logic                    mm_start_reg,
    output logic                    mm_clear_done,
    output logic [AWIDTH-1:0]       mm_addr_a,
    output logic [AWIDTH-1:0]       mm_addr_b,
    output logic [AWIDTH-1:0]       mm_addr_c,
    output logic [MAT_MUL_SIZE-1:0] mm_mask_a_rows,
    output logic [MAT_MUL_SIZE-1:0] mm_mask_k,
    output logic [MAT_MUL_SIZE-1:0] mm_mask_b_cols
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DIM_WIDTH-1:0] MAX_K    = DIM_WIDTH'(TILE_EDGE);
    localparam logic [DIM_WIDTH-1:0] MAX_MN   = DIM_WIDTH'(MAX_TILES * TILE_EDGE);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_d;
    seq_err_t   err_q, err_d;

    logic [DIM_WIDTH-1:0]    m_q, m_d, n_q, n_d, k_q, k_d;
    logic [AWIDTH-1:0]       base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic [STEP_WIDTH-1:0]   step_a_q, step_a_d, step_b_q, step_b_d;
    logic [STEP_WIDTH-1:0]   step_cc_q, step_cc_d, step_cr_q, step_cr_d;
    logic [TILE_IDX_W-1:0]   last_tr_q, last_tr_d, last_tc_q, last_tc_d;
    logic                    abort_q, abort_d;
    logic [7:0]              tiles_done_q, tiles_done_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    start_q, start_d, clear_q, clear_d;
    logic [AWIDTH-1:0]       addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [MAT_MUL_SIZE-1:0] mask_a_q, mask_a_d, mask_k_q, mask_k_d, mask_b_q, mask_b_d;

    logic                    ag_clear, ag_inc_col, ag_inc_row;
    logic [TILE_IDX_W-1:0]   ag_tile_row, ag_tile_col;
    logic [AWIDTH-1:0]       ag_addr_a, ag_addr_b, ag_addr_c;
    logic [DIM_WIDTH-1:0]    rows_left, cols_left;
    logic                    cfg_bad;

    matmul_tile_addr_gen #(
        .AWIDTH     (AWIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (ag_clear),
        .inc_col    (ag_inc_col),
        .inc_row    (ag_inc_row),
        .base_a     (base_a_q),
        .base_b     (base_b_q),
        .base_c     (base_c_q),
        .step_a     (step_a_q),
        .step_b     (step_b_q),
        .step_c_col (step_cc_q),
        .step_c_row (step_cr_q),
        .tile_row   (ag_tile_row),
        .tile_col   (ag_tile_col),
        .addr_a     (ag_addr_a),
        .addr_b     (ag_addr_b),
        .addr_c     (ag_addr_c)
    );

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        m_d          = m_q;
        n_d          = n_q;
        k_d          = k_q;
        base_a_d     = base_a_q;
        base_b_d     = base_b_q;
        base_c_d     = base_c_q;
        step_a_d     = step_a_q;
        step_b_d     = step_b_q;
        step_cc_d    = step_cc_q;
        step_cr_d    = step_cr_q;
        last_tr_d    = last_tr_q;
        last_tc_d    = last_tc_q;
        abort_d      = abort_q;
        tiles_done_d = tiles_done_q;
        timer_d      = timer_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        addr_c_d     = addr_c_q;
        mask_a_d     = mask_a_q;
        mask_k_d     = mask_k_q;
        mask_b_d     = mask_b_q;
        ag_clear     = 1'b0;
        ag_inc_col   = 1'b0;
        ag_inc_row   = 1'b0;

        // Elements of the current tile still inside the matrix (never negative for a valid job).
        rows_left = m_q - (DIM_WIDTH'(ag_tile_row) << TILE_SHIFT);
        cols_left = n_q - (DIM_WIDTH'(ag_tile_col) << TILE_SHIFT);
        cfg_bad   = (m_q == '0) || (n_q == '0) || (k_q == '0) ||
                    (k_q > MAX_K) || (m_q > MAX_MN) || (n_q > MAX_MN);

        // Sticky abort; a request in IDLE (even alongside cfg_start) is discarded.
        if (state_q != ST_IDLE && cfg_abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    m_d          = cfg_m;
                    n_d          = cfg_n;
                    k_d          = cfg_k;
                    base_a_d     = cfg_base_a;
                    base_b_d     = cfg_base_b;
                    base_c_d     = cfg_base_c;
                    step_a_d     = cfg_step_a;
                    step_b_d     = cfg_step_b;
                    step_cc_d    = cfg_step_c_col;
                    step_cr_d    = cfg_step_c_row;
                    abort_d      = 1'b0;
                    err_d        = ERR_OK;
                    tiles_done_d = '0;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_bad) begin
                    err_d   = ERR_BAD_CFG;
                    state_d = ST_DONE;
                end else begin
                    // Index of the last tile = ceil(dim/8) - 1 = (dim-1) >> 3.
                    last_tr_d = TILE_IDX_W'((m_q - 1'b1) >> TILE_SHIFT);
                    last_tc_d = TILE_IDX_W'((n_q - 1'b1) >> TILE_SHIFT);
                    mask_k_d  = mask_from_count(32'(k_q));
                    ag_clear  = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                addr_a_d = ag_addr_a;
                addr_b_d = ag_addr_b;
                addr_c_d = ag_addr_c;
                mask_a_d = mask_from_count(32'(rows_left));
                mask_b_d = mask_from_count(32'(cols_left));
                state_d  = ST_START;
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mm_done) begin
                    tiles_done_d = tiles_done_q + 8'd1;
                    state_d      = ST_CLEAR;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_CLEAR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (err_q != ERR_OK || abort_q || cfg_abort) begin
                    if (err_q == ERR_OK) begin
                        err_d = ERR_ABORTED;
                    end
                    state_d = ST_DONE;
                end else if (ag_tile_row == last_tr_q && ag_tile_col == last_tc_q) begin
                    state_d = ST_DONE;
                end else begin
                    if (ag_tile_col == last_tc_q) begin
                        ag_inc_row = 1'b1;
                    end else begin
                        ag_inc_col = 1'b1;
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status/control outputs are registered decodes of the next state. Start is high
        // only in WAIT_DONE and clear only in CLEAR, so they can never overlap.
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        start_d = (state_d == ST_WAIT_DONE);
        clear_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_OK;
            m_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            base_a_q     <= '0;
            base_b_q     <= '0;
            base_c_q     <= '0;
            step_a_q     <= '0;
            step_b_q     <= '0;
            step_cc_q    <= '0;
            step_cr_q    <= '0;
            last_tr_q    <= '0;
            last_tc_q    <= '0;
            abort_q      <= 1'b0;
            tiles_done_q <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_q      <= 1'b0;
            clear_q      <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_c_q     <= '0;
            mask_a_q     <= '0;
            mask_k_q     <= '0;
            mask_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            m_q          <= m_d;
            n_q          <= n_d;
            k_q          <= k_d;
            base_a_q     <= base_a_d;
            base_b_q     <= base_b_d;
            base_c_q     <= base_c_d;
            step_a_q     <= step_a_d;
            step_b_q     <= step_b_d;
            step_cc_q    <= step_cc_d;
            step_cr_q    <= step_cr_d;
            last_tr_q    <= last_tr_d;
            last_tc_q    <= last_tc_d;
            abort_q      <= abort_d;
            tiles_done_q <= tiles_done_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_q      <= start_d;
            clear_q      <= clear_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            addr_c_q     <= addr_c_d;
            mask_a_q     <= mask_a_d;
            mask_k_q     <= mask_k_d;
            mask_b_q     <= mask_b_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign tiles_done     = tiles_done_q;
    assign mm_start_reg   = start_q;
    assign mm_clear_done  = clear_q;
    assign mm_addr_a      = addr_a_q;
    assign mm_addr_b      = addr_b_q;
    assign mm_addr_c      = addr_c_q;
    assign mm_mask_a_rows = mask_a_q;
    assign mm_mask_k      = mask_k_q;
    assign mm_mask_b_cols = mask_b_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
module tb_matmul_tile_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_start, cfg_abort;
    logic [7:0]  cfg_m, cfg_n, cfg_k;
    logic [10:0] cfg_base_a, cfg_base_b, cfg_base_c;
    logic [7:0]  cfg_step_a, cfg_step_b, cfg_step_c_col, cfg_step_c_row;
    logic        busy, done;
    logic [1:0]  err;
    logic [7:0]  tiles_done;
    logic        mm_done, mm_start_reg, mm_clear_done;
    logic [10:0] mm_addr_a, mm_addr_b, mm_addr_c;
    logic [7:0]  mm_mask_a_rows, mm_mask_k, mm_mask_b_cols;

    always #5 clk = ~clk;

    matmul_tile_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_m          (cfg_m),
        .cfg_n          (cfg_n),
        .cfg_k          (cfg_k),
        .cfg_base_a     (cfg_base_a),
        .cfg_base_b     (cfg_base_b),
        .cfg_base_c     (cfg_base_c),
        .cfg_step_a     (cfg_step_a),
        .cfg_step_b     (cfg_step_b),
        .cfg_step_c_col (cfg_step_c_col),
        .cfg_step_c_row (cfg_step_c_row),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .tiles_done     (tiles_done),
        .mm_done        (mm_done),
        .mm_start_reg   (mm_start_reg),
        .mm_clear_done  (mm_clear_done),
        .mm_addr_a      (mm_addr_a),
        .mm_addr_b      (mm_addr_b),
        .mm_addr_c      (mm_addr_c),
        .mm_mask_a_rows (mm_mask_a_rows),
        .mm_mask_k      (mm_mask_k),
        .mm_mask_b_cols (mm_mask_b_cols)
    );

    typedef struct packed {
        logic [10:0] a, b, c;
        logic [7:0]  ma, mk, mb;
    } tile_t;
    typedef struct packed {
        logic [1:0] err;
        logic [7:0] tiles;
    } job_t;
    typedef struct {
        int m, n, k, ba, bb, bc, sa, sb, scc, scr;
    } job_cfg_t;

    tile_t tile_q[$];
    job_t  job_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int tiles_seen = 0;
    int clears_seen = 0;
    int last_start_len = 0;
    logic dp_hang = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: enumerate output tiles row-major from the job dimensions.
    function automatic logic [7:0] ref_mask(input int cnt);
        int v;
        if (cnt >= 8) return 8'hFF;
        v = (1 << cnt) - 1;
        return v[7:0];
    endfunction

    // mode 0: normal, 1: datapath hangs on first tile. abort_after>0: stop after that many tiles.
    function automatic void model_job(input job_cfg_t c, input int mode, input int abort_after);
        int tm, tn, idx, va, vb, vc;
        tile_t t;
        job_t  j;
        if (c.m == 0 || c.n == 0 || c.k == 0 || c.k > 8 || c.m > 128 || c.n > 128) begin
            j.err = 2'b01; j.tiles = 8'd0;
            job_q.push_back(j);
            return;
        end
        tm = (c.m + 7) / 8;
        tn = (c.n + 7) / 8;
        idx = 0;
        for (int r = 0; r < tm; r++) begin
            for (int q = 0; q < tn; q++) begin
                if ((mode == 1 && idx >= 1) || (abort_after > 0 && idx >= abort_after)) continue;
                va = (c.ba + r * c.sa) % 2048;
                vb = (c.bb + q * c.sb) % 2048;
                vc = (c.bc + r * c.scr + q * c.scc) % 2048;
                t.a = va[10:0]; t.b = vb[10:0]; t.c = vc[10:0];
                t.ma = ref_mask(c.m - 8 * r);
                t.mk = ref_mask(c.k);
                t.mb = ref_mask(c.n - 8 * q);
                tile_q.push_back(t);
                idx++;
            end
        end
        if (mode == 1) begin
            j.err = 2'b10; j.tiles = 8'd0;
        end else if (abort_after > 0) begin
            j.err = 2'b11; j.tiles = 8'(abort_after);
        end else begin
            j.err = 2'b00; j.tiles = 8'(tm * tn);
        end
        job_q.push_back(j);
    endfunction

    // Datapath stand-in: raise done a few cycles into a start, drop it on clear.
    initial begin
        int cnt, target;
        mm_done = 1'b0;
        cnt = 0;
        target = 3;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn || mm_clear_done) begin
                mm_done = 1'b0;
                cnt = 0;
                target = $urandom_range(6, 2);
            end else if (mm_start_reg && !mm_done && !dp_hang) begin
                cnt++;
                if (cnt >= target) mm_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic start_prev, clear_prev;
        int start_len;
        tile_t t;
        job_t j;
        start_prev = 1'b0;
        clear_prev = 1'b0;
        start_len = 0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (mm_start_reg && !start_prev) begin
                    tiles_seen++;
                    start_len = 0;
                    if (tile_q.size() == 0) begin
                        check("unexpected_tile", 64'({mm_addr_a, mm_addr_b, mm_addr_c}), 64'd0 - 64'd1);
                    end else begin
                        t = tile_q.pop_front();
                        check("tile", 64'({busy, mm_addr_a, mm_addr_b, mm_addr_c, mm_mask_a_rows,
                                           mm_mask_k, mm_mask_b_cols}), 64'({1'b1, t}));
                        $display("tile %0d: a=%h b=%h c=%h mask_a=%h mask_k=%h mask_b=%h", tiles_seen,
                                 mm_addr_a, mm_addr_b, mm_addr_c, mm_mask_a_rows, mm_mask_k, mm_mask_b_cols);
                    end
                end
                if (mm_start_reg) start_len++;
                if (!mm_start_reg && start_prev) last_start_len = start_len;
                if (mm_clear_done) begin
                    clears_seen++;
                    check("clear_vs_start", 64'(mm_start_reg), 64'd0);
                    if (clear_prev) check("clear_width", 64'(clear_prev), 64'd0);
                end
                if (done) begin
                    if (job_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        j = job_q.pop_front();
                        check("job_end", 64'({busy, err, tiles_done}), 64'({1'b0, j}));
                        $display("job done: err=%b tiles_done=%0d", err, tiles_done);
                    end
                end
            end
            start_prev = mm_start_reg;
            clear_prev = mm_clear_done;
        end
    end

    task automatic start_job(input job_cfg_t c, input logic with_abort);
        @(posedge clk);
        #1;
        cfg_m = 8'(c.m); cfg_n = 8'(c.n); cfg_k = 8'(c.k);
        cfg_base_a = 11'(c.ba); cfg_base_b = 11'(c.bb); cfg_base_c = 11'(c.bc);
        cfg_step_a = 8'(c.sa); cfg_step_b = 8'(c.sb);
        cfg_step_c_col = 8'(c.scc); cfg_step_c_row = 8'(c.scr);
        cfg_start = 1'b1;
        cfg_abort = with_abort;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_tiles(input int target, input int limit);
        int n;
        n = 0;
        while (!(tiles_seen >= target && mm_start_reg) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tile_reached", 64'(tiles_seen >= target && mm_start_reg), 64'd1);
    endtask

    initial begin
        job_cfg_t c;
        int n, s0, c0;
        resetn = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_m = '0; cfg_n = '0; cfg_k = '0;
        cfg_base_a = '0; cfg_base_b = '0; cfg_base_c = '0;
        cfg_step_a = '0; cfg_step_b = '0; cfg_step_c_col = '0; cfg_step_c_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", 64'({busy, done, err, tiles_done, mm_start_reg, mm_clear_done}), 64'd0);
        check("reset_datapath", 64'({mm_addr_a, mm_addr_b, mm_addr_c, mm_mask_a_rows, mm_mask_k,
                                     mm_mask_b_cols}), 64'd0);
        resetn = 1'b1;

        // 1: single tile; abort together with start in IDLE is ignored.
        c = '{8, 8, 8, 0, 64, 128, 0, 0, 0, 0};
        model_job(c, 0, 0);
        start_job(c, 1'b1);
        n = 0;
        while (!mm_start_reg && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("start_latency", 64'(n), 64'd3);
        wait_done(3000, n);

        // 2: 3x2 tiles with partial masks; a second cfg_start mid-job is ignored.
        c = '{20, 10, 5, 100, 200, 300, 8, 8, 8, 16};
        model_job(c, 0, 0);
        s0 = tiles_seen;
        start_job(c, 1'b0);
        wait_tiles(s0 + 2, 500);
        cfg_m = 8'd3;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        wait_done(3000, n);

        // 3: bad configurations never start a tile.
        c = '{8, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        model_job(c, 0, 0);
        start_job(c, 1'b0);
        wait_done(20, n);
        check("bad_k_latency", 64'(n <= 2), 64'd1);
        c = '{129, 8, 4, 0, 0, 0, 0, 0, 0, 0};
        model_job(c, 0, 0);
        start_job(c, 1'b0);
        wait_done(20, n);
        c = '{8, 0, 4, 0, 0, 0, 0, 0, 0, 0};
        model_job(c, 0, 0);
        start_job(c, 1'b0);
        wait_done(20, n);

        // 4: datapath never finishes.
        dp_hang = 1'b1;
        c = '{8, 8, 8, 5, 6, 7, 0, 0, 0, 0};
        model_job(c, 1, 0);
        c0 = clears_seen;
        start_job(c, 1'b0);
        wait_done(3000, n);
        check("timeout_start_len", 64'(last_start_len), 64'd1024);
        check("timeout_clears", 64'(clears_seen - c0), 64'd1);
        dp_hang = 1'b0;

        // 5: abort during the second of six tiles.
        c = '{20, 10, 5, 100, 200, 300, 8, 8, 8, 16};
        model_job(c, 0, 2);
        s0 = tiles_seen;
        start_job(c, 1'b0);
        wait_tiles(s0 + 2, 500);
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        wait_done(3000, n);

        // 6: reset while waiting on the datapath, then a fresh job.
        dp_hang = 1'b1;
        c = '{16, 16, 8, 1, 2, 3, 8, 8, 8, 16};
        model_job(c, 0, 0);
        s0 = tiles_seen;
        start_job(c, 1'b0);
        wait_tiles(s0 + 1, 50);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midjob_reset", 64'({busy, done, err, tiles_done, mm_start_reg, mm_clear_done}), 64'd0);
        check("midjob_reset_dp", 64'({mm_addr_a, mm_addr_b, mm_addr_c, mm_mask_a_rows, mm_mask_k,
                                       mm_mask_b_cols}), 64'd0);
        tile_q.delete();
        job_q.delete();
        resetn = 1'b1;
        dp_hang = 1'b0;
        c = '{8, 16, 3, 10, 20, 30, 40, 50, 60, 70};
        model_job(c, 0, 0);
        start_job(c, 1'b0);
        wait_done(3000, n);

        // Random jobs, including address wrap.
        for (int i = 0; i < 20; i++) begin
            c.m = $urandom_range(40, 1);
            c.n = $urandom_range(40, 1);
            c.k = $urandom_range(8, 1);
            c.ba = $urandom_range(2047, 0);
            c.bb = $urandom_range(2047, 0);
            c.bc = $urandom_range(2047, 0);
            c.sa = $urandom_range(255, 0);
            c.sb = $urandom_range(255, 0);
            c.scc = $urandom_range(255, 0);
            c.scr = $urandom_range(255, 0);
            model_job(c, 0, 0);
            start_job(c, 1'b0);
            wait_done(3000, n);
        end

        repeat (3) @(posedge clk);
        #1;
        check("tiles_left", 64'(tile_q.size()), 64'd0);
        check("jobs_left", 64'(job_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
